cla_digit_serial_seq: RTL

- Digit-serial 15-bit adder/subtractor controller. It sequences a single 3-bit carry-lookahead add/sub slice over 5 consecutive cycles, least-significant digit first.
- Carry is chained between digits through a register.
- Sits between a requester (valid/ready operand interface) and a consumer (valid/ready result interface). It trades throughput for area against the fully parallel 15-bit CLA.

---
 rtl/cla_seq_pkg.sv | 15 +
 rtl/CLA_3bit.sv | 28 ++
 rtl/cla_digit_serial_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared widths and FSM state type for the digit-serial CLA sequencer
package cla_seq_pkg;

    localparam int WIDTH   = 15;
    localparam int DIGIT_W = 3;
    localparam int NDIGITS = WIDTH / DIGIT_W;
    localparam int IDX_W   = $clog2(NDIGITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/CLA_3bit.sv
// rtl/CLA_3bit.sv - combinational 3-bit carry-lookahead add/sub slice (mode=1 inverts D)
module CLA_3bit (
    input  logic [2:0] C,
    input  logic [2:0] D,
    input  logic       Cin,
    input  logic       mode,
    output logic [2:0] RES,
    output logic       Carry
);

    logic [2:0] d_eff;
    logic [2:0] p;
    logic [2:0] g;
    logic [3:0] c;

    always_comb begin
        d_eff = D ^ {3{mode}};
        p     = C ^ d_eff;
        g     = C & d_eff;
        c[0]  = Cin;
        c[1]  = g[0] | (p[0] & Cin);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
        RES   = p ^ c[2:0];
        Carry = c[3];
    end

endmodule

// File: rtl/cla_digit_serial_seq.sv
// rtl/cla_digit_serial_seq.sv - digit-serial add/sub: one 3-bit CLA slice reused over NDIGITS cycles, LSD first
module cla_digit_serial_seq #(
    parameter int WIDTH   = 15,
    parameter int DIGIT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);
    import cla_seq_pkg::*;

    localparam int NDIGITS = WIDTH / DIGIT_W;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mode_q, mode_d;
    logic               cin_q, cin_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;

    logic [DIGIT_W-1:0] slice_c;
    logic [DIGIT_W-1:0] slice_d;
    logic [DIGIT_W-1:0] slice_res;
    logic               slice_carry;

    CLA_3bit u_slice (
        .C     (slice_c),
        .D     (slice_d),
        .Cin   (cin_q),
        .mode  (mode_q),
        .RES   (slice_res),
        .Carry (slice_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
            cin_q      <= 1'b0;
            idx_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
            cin_q      <= cin_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    // Digit select driven by the index register; only the selected digit is written back.
    always_comb begin
        slice_c = '0;
        slice_d = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_c = a_q[i*DIGIT_W +: DIGIT_W];
                slice_d = b_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        cin_d      = cin_q;
        idx_d      = idx_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    cin_d   = mode;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NDIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[i*DIGIT_W +: DIGIT_W] = slice_res;
                    end
                end
                cin_d = slice_carry;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NDIGITS - 1)) begin
                    // The MSB of the result is being produced this cycle, so take it from the slice.
                    carry_d    = slice_carry;
                    overflow_d = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ mode_q)) &&
                                 (slice_res[DIGIT_W-1] != a_q[WIDTH-1]);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result    = result_q;
        carry     = carry_q;
        overflow  = overflow_q;
    end

endmodule
